mem_access_unit: RTL and testbench

Memory-stage controller of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. It turns the registered load/store of the instruction in MEM into a req/ack transaction on the data-memory bus, and stalls the pipeline until the transaction completes. It also aligns and extends load data into `ReaddataM` and flags misaligned or timed-out accesses.

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/load_align.sv | 38 +++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_pkg : shared encodings, FSM states and lane helpers for MEM stage
// Rev 1.0
// ------------------------------------------------------------------
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  // Reserved size 2'b11 behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lane_enables(input logic       is_store,
                                              input logic [1:0] size,
                                              input logic [1:0] off);
    logic [3:0] be;
    if (!is_store) begin
      be = 4'b1111;
    end else begin
      case (size)
        SZ_BYTE: be = 4'b0001 << off;
        SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                 input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{data[7:0]}};
      SZ_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_access_unit_if : data-memory req/ack bus
// Rev 1.0
// ------------------------------------------------------------------
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ------------------------------------------------------------------
// load_align : lane select and sign/zero extension of load data
// Rev 1.0
// ------------------------------------------------------------------
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: result_o = {{24{byte_sel[7]  & ~unsigned_i}}, byte_sel};
      SZ_HALF: result_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_access_unit : MEM-stage load/store bus controller with stall
// Rev 1.0
// ------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     MemreadM,
  input  logic                     MemwriteM,
  input  logic [1:0]               SizeM,
  input  logic                     UnsignedM,
  input  logic [31:0]              ALUoutM,
  input  logic [31:0]              WritedataM,
  mem_access_unit_if.master        dmem,
  output logic                     StallM,
  output logic [31:0]              ReaddataM,
  output logic                     AlignErrM,
  output logic                     BusErrM
);

  mau_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [31:0]      readdata_q;
  logic             align_err_q;
  logic             bus_err_q;

  logic             mem_op_d;
  logic             misalign_d;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d;
  logic [31:0]      load_data_d;
  logic             timeout_d;

  assign mem_op_d   = MemreadM | MemwriteM;
  assign misalign_d = is_misaligned(SizeM, ALUoutM[1:0]);
  assign be_d       = lane_enables(MemwriteM, SizeM, ALUoutM[1:0]);
  assign wdata_d    = lane_replicate(SizeM, WritedataM);
  assign timeout_d  = (cnt_q == CNT_W'(TIMEOUT - 1));

  load_align u_load_align (
    .rdata_i    (dmem.dmem_rdata),
    .addr_i     (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      readdata_q  <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          readdata_q <= '0;
          if (mem_op_d) begin
            if (misalign_d) begin
              align_err_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              we_q    <= MemwriteM;
              addr_q  <= {ALUoutM[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              off_q   <= ALUoutM[1:0];
              size_q  <= SizeM;
              uns_q   <= UnsignedM;
              cnt_q   <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            readdata_q <= we_q ? 32'h0 : load_data_d;
            cnt_q      <= '0;
            state_q    <= DONE;
          end else if (timeout_d) begin
            readdata_q <= '0;
            bus_err_q  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Unconditional return to IDLE keeps a still-present op from re-issuing.
          readdata_q <= '0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  // Gated by rst_n so the stall drops with reset even while an op is presented.
  assign StallM    = rst_n & (((state_q == IDLE) & mem_op_d) | (state_q == BUSY));
  assign ReaddataM = readdata_q;
  assign AlignErrM = align_err_q;
  assign BusErrM   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mem_access_unit : random + directed check against a behavioural model
// Rev 1.0
// ------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemreadM, MemwriteM, UnsignedM;
  logic [1:0]  SizeM;
  logic [31:0] ALUoutM, WritedataM;
  logic        StallM, AlignErrM, BusErrM;
  logic [31:0] ReaddataM;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemreadM   (MemreadM),
    .MemwriteM  (MemwriteM),
    .SizeM      (SizeM),
    .UnsignedM  (UnsignedM),
    .ALUoutM    (ALUoutM),
    .WritedataM (WritedataM),
    .dmem       (bus),
    .StallM     (StallM),
    .ReaddataM  (ReaddataM),
    .AlignErrM  (AlignErrM),
    .BusErrM    (BusErrM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                         input logic [31:0] a, input logic uns);
    logic [31:0] sh, v;
    sh = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = sh & 32'hFF;
      if (!uns) v = (v ^ 32'h80) - 32'h80;
    end else if (sz == 2'd1) begin
      v = sh & 32'hFFFF;
      if (!uns) v = (v ^ 32'h8000) - 32'h8000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] m;
    if (!wr || sz >= 2'd2) return 4'hF;
    m = (sz == 2'd0) ? (32'd1 << (a % 4)) : (32'd3 << (a % 4));
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One instruction through MEM; delay = BUSY cycles before ack (>= TMO never acks).
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int delay,
                        input logic [31:0] rdv);
    bit          mis, tout, ackv;
    logic [31:0] exp_rd;
    @(negedge clk);
    MemreadM = rd; MemwriteM = wr; SizeM = sz; UnsignedM = uns;
    ALUoutM = a; WritedataM = wd;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
    #1;
    check("idle_stall", {31'd0, StallM}, {31'd0, rd | wr});
    check("idle_req", {31'd0, bus.dmem_req}, 32'd0);
    check("idle_rdata", ReaddataM, 32'd0);
    check("idle_errs", {30'd0, AlignErrM, BusErrM}, 32'd0);
    if (!(rd | wr)) begin
      @(posedge clk);
      return;
    end
    @(posedge clk);
    mis  = m_misaligned(sz, a);
    tout = !mis && (delay >= TMO);
    if (!mis) begin
      for (int i = 0; i < TMO; i++) begin
        @(negedge clk);
        ackv = (i == delay);
        bus.dmem_ack   = ackv;
        bus.dmem_rdata = ackv ? rdv : $urandom;
        #1;
        check("busy_req", {31'd0, bus.dmem_req}, 32'd1);
        check("busy_stall", {31'd0, StallM}, 32'd1);
        check("busy_we", {31'd0, bus.dmem_we}, {31'd0, wr});
        check("busy_addr", bus.dmem_addr, a & 32'hFFFF_FFFC);
        check("busy_be", {28'd0, bus.dmem_be}, {28'd0, m_be(wr, sz, a)});
        if (wr) check("busy_wdata", bus.dmem_wdata, m_wdata(sz, wd));
        check("busy_rdata", ReaddataM, 32'd0);
        @(posedge clk);
        if (ackv) break;
      end
    end
    @(negedge clk);
    bus.dmem_ack   = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    exp_rd = (mis || wr || tout) ? 32'd0 : m_load(rdv, sz, a, uns);
    #1;
    check("done_stall", {31'd0, StallM}, 32'd0);
    check("done_req", {31'd0, bus.dmem_req}, 32'd0);
    check("done_rdata", ReaddataM, exp_rd);
    check("done_alignerr", {31'd0, AlignErrM}, {31'd0, mis});
    check("done_buserr", {31'd0, BusErrM}, {31'd0, tout});
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    MemreadM = 1'b0; MemwriteM = 1'b0; SizeM = 2'd0; UnsignedM = 1'b0;
    ALUoutM = '0; WritedataM = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rst_we", {31'd0, bus.dmem_we}, 32'd0);
    check("rst_addr", bus.dmem_addr, 32'd0);
    check("rst_be", {28'd0, bus.dmem_be}, 32'd0);
    check("rst_wdata", bus.dmem_wdata, 32'd0);
    check("rst_outs", {29'd0, StallM, AlignErrM, BusErrM}, 32'd0);
    check("rst_rdata", ReaddataM, 32'd0);
    rst_n = 1'b1;

    run_op(1, 0, 2'd2, 0, 32'h100, 32'd0,        0, 32'hDEADBEEF);
    run_op(1, 0, 2'd0, 0, 32'h103, 32'd0,        1, 32'h80112233);
    run_op(1, 0, 2'd0, 1, 32'h103, 32'd0,        0, 32'h80112233);
    run_op(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 2, 32'd0);
    run_op(1, 0, 2'd2, 0, 32'h101, 32'd0,        0, 32'd0);
    run_op(1, 0, 2'd2, 0, 32'h104, 32'd0,        9, 32'h12345678);
    run_op(0, 0, 2'd0, 0, 32'h0,   32'd0,        0, 32'd0);
    run_op(1, 0, 2'd1, 0, 32'h106, 32'd0,        3, 32'h9ABC0000);

    // Reset during the third BUSY cycle.
    @(negedge clk);
    MemreadM = 1'b1; MemwriteM = 1'b0; SizeM = 2'd2; ALUoutM = 32'h300;
    bus.dmem_ack = 1'b0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_req", {31'd0, bus.dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, StallM}, 32'd0);
    @(negedge clk);
    MemreadM = 1'b0;
    rst_n = 1'b1;
    run_op(1, 0, 2'd2, 0, 32'h400, 32'd0, 1, 32'hCAFEF00D);

    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [1:0]  sz;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
      run_op(kind >= 2 && kind < 6, kind >= 6, sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, TMO + 1), $urandom);
    end

    @(negedge clk);
    MemreadM = 1'b0; MemwriteM = 1'b0; bus.dmem_ack = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
